// File: rtl/uart_frame_loader.sv
// UART (8N1) frame receiver that streams checksummed LED frames into the LED memory write port.
// Frame: SYNC, LEN_HI, LEN_LO, N = {LEN_HI[0], LEN_LO} + 1 data bytes, XOR checksum.
module uart_frame_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 12000
) (
    input  logic       clock_12mhz,
    input  logic       reset,
    input  logic       rx,
    output logic       write_enable,
    output logic [8:0] write_address,
    output logic [7:0] write_data,
    output logic       frame_done,
    output logic       frame_error,
    output logic       busy
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HUNT, P_LEN_HI, P_LEN_LO, P_DATA, P_CHECK} parse_state_t;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state, rx_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             half_tick, bit_tick;
    logic             byte_valid, byte_error;

    parse_state_t     p_state, p_next;
    logic             len_hi_bit;
    logic [8:0]       last_addr;
    logic [8:0]       addr;
    logic [7:0]       chk;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_hit, do_write, do_done, do_error;

    // rx is asynchronous; idle level is high so the synchronizer resets to 1
    always_ff @(posedge clock_12mhz) begin
        if (reset) {rx_meta, rx_sync} <= 2'b11;
        else       {rx_meta, rx_sync} <= {rx, rx_meta};
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        half_tick = 1'b0;
        bit_tick  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: begin
                half_tick = (bit_cnt == HALF_LAST);
                if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                bit_tick = (bit_cnt == BIT_LAST);
                if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: begin
                bit_tick = (bit_cnt == BIT_LAST);
                if (bit_tick) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Bit timing restarts at mid start bit, so every later sample lands mid-bit
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            byte_error <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_error <= 1'b0;
            if (rx_state == RX_IDLE || half_tick || bit_tick) bit_cnt <= '0;
            else                                              bit_cnt <= bit_cnt + BIT_W'(1);
            if (half_tick) bit_idx <= '0;
            if (rx_state == RX_DATA && bit_tick) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_state == RX_STOP && bit_tick) begin
                byte_valid <= rx_sync;
                byte_error <= !rx_sync;
            end
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) p_state <= P_HUNT;
        else       p_state <= p_next;
    end

    // A byte_valid in the timeout cycle takes priority and suppresses the abort
    always_comb begin
        p_next      = p_state;
        do_write    = 1'b0;
        do_done     = 1'b0;
        do_error    = 1'b0;
        timeout_hit = (p_state != P_HUNT) && (to_cnt == TO_LIMIT) && !byte_valid;
        if (p_state != P_HUNT && (byte_error || timeout_hit)) begin
            do_error = 1'b1;
            p_next   = P_HUNT;
        end else if (byte_valid) begin
            case (p_state)
                P_HUNT:   if (rx_byte == SYNC_BYTE) p_next = P_LEN_HI;
                P_LEN_HI: p_next = P_LEN_LO;
                P_LEN_LO: p_next = P_DATA;
                P_DATA: begin
                    do_write = 1'b1;
                    if (addr == last_addr) p_next = P_CHECK;
                end
                P_CHECK: begin
                    if (rx_byte == chk) do_done  = 1'b1;
                    else                do_error = 1'b1;
                    p_next = P_HUNT;
                end
                default: p_next = P_HUNT;
            endcase
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
            len_hi_bit    <= 1'b0;
            last_addr     <= '0;
            addr          <= '0;
            chk           <= '0;
            to_cnt        <= '0;
        end else begin
            write_enable <= do_write;
            frame_done   <= do_done;
            frame_error  <= do_error;
            if (byte_valid && p_state == P_LEN_HI) len_hi_bit <= rx_byte[0];
            if (byte_valid && p_state == P_LEN_LO) begin
                last_addr <= {len_hi_bit, rx_byte};
                addr      <= '0;
                chk       <= '0;
            end
            if (do_write) begin
                write_address <= addr;
                write_data    <= rx_byte;
                addr          <= addr + 9'd1;
                chk           <= chk ^ rx_byte;
            end
            if (p_state == P_HUNT || byte_valid) to_cnt <= '0;
            else if (to_cnt != TO_LIMIT)         to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign busy = (p_state != P_HUNT);

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Receives LED frames from a host over an 8N1 UART and writes the payload bytes into the LED memory write port, starting at address 0. It is the stage directly upstream of the LED memory: the host streams colour bytes in, and the selector/encoder path reads them back out. The block contains its own oversampling-free UART receiver, a frame parser with an XOR checksum, and an inter-byte timeout.

## Interface
Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 12000, maximum idle cycles between bytes inside a frame (1 ms).

Ports:
- clock_12mhz  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high.
- rx  input  1  UART line, idle high, asynchronous to clock_12mhz.
- write_enable  output  1  one-cycle memory write strobe.
- write_address  output  9  memory address, valid when write_enable=1.
- write_data  output  8  payload byte, valid when write_enable=1.
- frame_done  output  1  one-cycle pulse: frame accepted with good checksum.
- frame_error  output  1  one-cycle pulse: frame aborted or bad checksum.
- busy  output  1  high while the parser is in any state other than HUNT.

## Operation
- Synchronizer: rx passes through two flops before use.
- Receiver states: IDLE, START, DATA, STOP.
  - IDLE -> START on synced rx = 0.
  - START: wait CLKS_PER_BIT/2 (integer division). If rx = 1, false start -> IDLE. Otherwise -> DATA.
  - DATA: sample 8 bits, one every CLKS_PER_BIT, LSB first.
  - STOP: sample once after CLKS_PER_BIT. rx = 1 gives byte_valid; rx = 0 gives byte_error. Both are internal one-cycle strobes. Then -> IDLE.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N data bytes, then CHK.
  - N = {LEN_HI[0], LEN_LO} + 1, so 1..512. LEN_HI[7:1] is ignored.
  - CHK = XOR of the N data bytes.
- Parser states: HUNT, LEN_HI, LEN_LO, DATA, CHECK.
  - HUNT: byte == SYNC_BYTE -> LEN_HI. Other bytes and byte_error are ignored silently.
  - LEN_HI -> LEN_LO -> DATA: each on byte_valid. Entering DATA clears the address counter and the checksum accumulator.
  - DATA: on each byte_valid, write the byte, XOR it into the accumulator, increment the address. After the Nth byte -> CHECK.
  - CHECK: on byte_valid, compare with the accumulator. Match pulses frame_done; mismatch pulses frame_error. Either way -> HUNT.
  - A SYNC_BYTE value inside LEN/DATA/CHECK is ordinary data. There is no resynchronisation mid-frame.
- Abort conditions (any state except HUNT) pulse frame_error and go to HUNT:
  - byte_error;
  - the timeout counter reaching TIMEOUT_CLKS.
- Timeout counter:
  - cleared on every byte_valid and whenever in HUNT;
  - otherwise increments by 1 per cycle, saturating.
- Writes are streamed. On bad checksum or abort, memory holds a partial frame. The block does not roll back.
- Address width: 9 bits, at most 512 writes per frame. The counter never wraps within a frame.

## Timing
- Reset: parser in HUNT, receiver in IDLE, counters 0. All outputs are 0: write_enable, write_address, write_data, frame_done, frame_error, busy.
- Reset asserted mid-frame abandons the frame with no pulses. Reset mid-byte discards the partial byte.
- Latency: byte_valid/byte_error registers on the edge that samples the stop bit (edge T).
  - write_enable, frame_done and frame_error are registered outputs, high for exactly the cycle after edge T+1.
- write_address and write_data are stable during the write_enable cycle and hold their value afterwards.
- busy:
  - rises the cycle after the SYNC byte's T+1 edge;
  - falls in the same cycle as the frame_done/frame_error pulse.
- frame_done and frame_error are never high in the same cycle. At most one of them pulses per frame.
- Timeout fires on the cycle the counter equals TIMEOUT_CLKS. A byte_valid in that same cycle wins: the counter clears and there is no abort.
- Back-to-back frames: a SYNC byte arriving immediately after CHK is accepted, with no idle gap required.

## Test plan
- Valid frame. Send A5 00 02 11 22 33 00 at 115200 baud. Required: writes (0,11), (1,22), (2,33) in order; one frame_done 2 edges after the CHK stop-bit sample; no frame_error; busy low afterwards.
- Bad checksum. Send A5 00 02 11 22 33 FF. Required: the same three writes, one frame_error pulse, no frame_done.
- Garbage before sync. Send 00 5A FF, a byte with stop bit forced low, then the valid frame from the first test. Required: only the three frame writes occur and no frame_error.
- Maximum length. Send A5 01 FF, then bytes k[7:0] for k = 0..511, then CHK = 00. Required: 512 writes at addresses 0..511 with data equal to the address LSBs, then frame_done.
- Timeout. Send A5 00 01 11, then hold rx high. Required: frame_error exactly TIMEOUT_CLKS cycles after the 11 byte's byte_valid, and busy falls. A following valid frame is then accepted.
- Reset mid-frame. Assert reset for 1 cycle after the second data byte, then send a valid 1-byte frame A5 00 00 7E 7E. Required: no pulse from the aborted frame, outputs 0 during reset, then write (0,7E) and frame_done.
